// File: rtl/wb_shared_arbiter_pkg.sv
// Shared types and widths for the two-master Wishbone arbiter.
package wb_shared_arbiter_pkg;
  localparam int WB_DATA_WIDTH     = 32;
  localparam int WB_SEL_WIDTH      = 4;
  localparam int TIMEOUT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention the requester not in 'last' wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (&req) gnt = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/wb_shared_arbiter.sv
// Two-master, one-slave Wishbone B4 pipelined arbiter with round-robin grant,
// one outstanding transaction and a watchdog that turns a silent slave into err.
module wb_shared_arbiter
  import wb_shared_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m0_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_we_i,
  input  logic [ADDR_WIDTH-1:0]    m0_adr_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_dat_i,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,
  output logic                     m0_rty_o,
  output logic                     m0_stall_o,
  output logic [WB_DATA_WIDTH-1:0] m0_dat_o,
  input  logic                     m1_cyc_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_we_i,
  input  logic [ADDR_WIDTH-1:0]    m1_adr_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_dat_i,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,
  output logic                     m1_rty_o,
  output logic                     m1_stall_o,
  output logic [WB_DATA_WIDTH-1:0] m1_dat_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [ADDR_WIDTH-1:0]    wb_adr_o,
  output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i,
  input  logic                     wb_stall_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [TIMEOUT_CNT_WIDTH-1:0] TIMEOUT_CNT = TIMEOUT_CNT_WIDTH'(TIMEOUT);

  logic [1:0]                   state;
  logic                         last_grant;
  logic                         grant;
  logic [TIMEOUT_CNT_WIDTH-1:0] cnt;

  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] accept;
  logic       busy;
  logic       g_cyc;
  logic       resp;
  logic       timeout;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  rr_pick2 u_pick (
    .req  (req),
    .last (last_grant),
    .gnt  (gnt)
  );

  // Accepts only happen in IDLE outside reset, so requesters see stall during reset.
  assign accept     = gnt & {2{(state == S_IDLE) && !rst_i}};
  assign m0_stall_o = req[0] & ~accept[0];
  assign m1_stall_o = req[1] & ~accept[1];

  assign busy     = (state == S_REQ) || (state == S_WAIT);
  assign wb_cyc_o = busy;
  assign wb_stb_o = (state == S_REQ);

  assign g_cyc   = grant ? m1_cyc_i : m0_cyc_i;
  assign resp    = wb_ack_i | wb_err_i | wb_rty_i;
  assign timeout = (cnt == TIMEOUT_CNT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cnt        <= '0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_sel_o   <= '0;
      wb_dat_o   <= '0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_rty_o   <= 1'b0;
      m0_dat_o   <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_rty_o   <= 1'b0;
      m1_dat_o   <= '0;
    end else begin
      m0_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m0_rty_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m1_err_o <= 1'b0;
      m1_rty_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|accept) begin
            state      <= S_REQ;
            grant      <= accept[1];
            last_grant <= accept[1];
            cnt        <= '0;
            wb_we_o    <= accept[1] ? m1_we_i  : m0_we_i;
            wb_adr_o   <= accept[1] ? m1_adr_i : m0_adr_i;
            wb_sel_o   <= accept[1] ? m1_sel_i : m0_sel_i;
            wb_dat_o   <= accept[1] ? m1_dat_i : m0_dat_i;
          end
        end
        S_REQ, S_WAIT: begin
          cnt <= cnt + TIMEOUT_CNT_WIDTH'(1);
          // Priority: master abort, then slave response (even while stalled), then watchdog.
          if (!g_cyc) begin
            state <= S_IDLE;
          end else if (resp) begin
            state <= S_IDLE;
            if (grant) begin
              m1_ack_o <= wb_ack_i;
              m1_err_o <= wb_err_i;
              m1_rty_o <= wb_rty_i;
              m1_dat_o <= wb_dat_i;
            end else begin
              m0_ack_o <= wb_ack_i;
              m0_err_o <= wb_err_i;
              m0_rty_o <= wb_rty_i;
              m0_dat_o <= wb_dat_i;
            end
          end else if (timeout) begin
            state <= S_IDLE;
            if (grant) m1_err_o <= 1'b1;
            else       m0_err_o <= 1'b1;
          end else if ((state == S_REQ) && !wb_stall_i) begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_shared_arbiter.sv
// Self-checking bench for wb_shared_arbiter: vector table, corner-case sequences
// and randomized transactions against a transaction-level reference model.
module tb_wb_shared_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [7:0] m0_adr = '0;
  logic [3:0] m0_sel = '0;
  logic [31:0] m0_dat = '0;
  logic m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [7:0] m1_adr = '0;
  logic [3:0] m1_sel = '0;
  logic [31:0] m1_dat = '0;
  logic m0_ack, m0_err, m0_rty, m0_stall, m1_ack, m1_err, m1_rty, m1_stall;
  logic [31:0] m0_dout, m1_dout;
  logic wb_cyc, wb_stb, wb_we;
  logic [7:0] wb_adr;
  logic [3:0] wb_sel;
  logic [31:0] wb_dout;
  logic wb_ack = 0, wb_err = 0, wb_rty = 0, wb_stall = 0;
  logic [31:0] wb_din = '0;

  always #5 clk = ~clk;

  wb_shared_arbiter #(.ADDR_WIDTH(8), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_rty_o(m0_rty), .m0_stall_o(m0_stall), .m0_dat_o(m0_dout),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_rty_o(m1_rty), .m1_stall_o(m1_stall), .m1_dat_o(m1_dout),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_sel_o(wb_sel), .wb_dat_o(wb_dout), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .wb_rty_i(wb_rty), .wb_stall_i(wb_stall), .wb_dat_i(wb_din)
  );

  typedef struct {
    bit          r0, r1;
    bit          we;
    logic [7:0]  adr0, adr1;
    logic [31:0] dat0, dat1;
    logic [3:0]  sel;
    int          lat;       // slave response cycle counted from REQ entry, -1 = never
    int          stl;       // cycles the slave holds stall from REQ entry
    int          kind;      // 0 ack, 1 err, 2 rty
    int          exp_g;
    int          exp_term;  // 0 ack, 1 err, 2 rty
    int          exp_cyc;   // cycles from REQ entry to visible termination
    logic [31:0] exp_dat;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] smem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] hold [2];
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] term_bits(input int t);
    return (t == 0) ? 3'b100 : (t == 1) ? 3'b010 : 3'b001;
  endfunction

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    wb_ack = 0; wb_err = 0; wb_rty = 0; wb_stall = 0;
  endtask

  task automatic reset_dut();
    idle_all();
    rst = 1;
    @(negedge clk);
    rst = 0;
    hold[0] = '0;
    hold[1] = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit early;
    int g;
    g = v.exp_g;
    m0_we = v.we; m1_we = v.we; m0_sel = v.sel; m1_sel = v.sel;
    m0_adr = v.adr0; m1_adr = v.adr1; m0_dat = v.dat0; m1_dat = v.dat1;
    m0_cyc = v.r0; m0_stb = v.r0; m1_cyc = v.r1; m1_stb = v.r1;
    #1;
    chk({tag, " stall0"}, 32'(m0_stall), 32'(v.r0 && g != 0));
    chk({tag, " stall1"}, 32'(m1_stall), 32'(v.r1 && g != 1));
    @(negedge clk);
    chk({tag, " req cyc/stb"}, {30'd0, wb_cyc, wb_stb}, 32'd3);
    chk({tag, " fwd adr"}, 32'(wb_adr), 32'(g ? v.adr1 : v.adr0));
    chk({tag, " fwd dat/we"}, wb_dout ^ 32'(wb_we), (g ? v.dat1 : v.dat0) ^ 32'(v.we));
    chk({tag, " fwd sel"}, 32'(wb_sel), 32'(v.sel));
    m0_stb = 0; m1_stb = 0;
    if (g == 0) m1_cyc = 0; else m0_cyc = 0;
    early = 0;
    for (int j = 0; j < v.exp_cyc; j++) begin
      wb_stall = (j < v.stl);
      wb_ack = (j == v.lat) && (v.kind == 0);
      wb_err = (j == v.lat) && (v.kind == 1);
      wb_rty = (j == v.lat) && (v.kind == 2);
      if (j == v.lat) begin
        wb_din = wb_we ? 32'h0 : smem[wb_adr];
        if (wb_we && v.kind == 0) smem[wb_adr] = wb_dout;
      end
      @(negedge clk);
      if (j + 1 < v.exp_cyc &&
          (m0_ack || m0_err || m0_rty || m1_ack || m1_err || m1_rty || !wb_cyc)) early = 1;
    end
    wb_ack = 0; wb_err = 0; wb_rty = 0; wb_stall = 0;
    chk({tag, " no early end"}, 32'(early), 32'd0);
    chk({tag, " cyc low at term"}, 32'(wb_cyc), 32'd0);
    chk({tag, " term m0"}, 32'({m0_ack, m0_err, m0_rty}), 32'(g == 0 ? term_bits(v.exp_term) : 3'b000));
    chk({tag, " term m1"}, 32'({m1_ack, m1_err, m1_rty}), 32'(g == 1 ? term_bits(v.exp_term) : 3'b000));
    hold[g] = v.exp_dat;
    chk({tag, " dat m0"}, m0_dout, hold[0]);
    chk({tag, " dat m1"}, m1_dout, hold[1]);
    if (v.we && v.kind == 0 && v.lat >= 0 && v.lat < v.exp_cyc)
      ref_mem[g ? v.adr1 : v.adr0] = g ? v.dat1 : v.dat0;
    idle_all();
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    int   r, mdl_last;
    for (int i = 0; i < 256; i++) begin smem[i] = '0; ref_mem[i] = '0; end
    hold[0] = '0; hold[1] = '0;

    //              r0 r1 we adr0   adr1   dat0          dat1          sel   lat stl k  g  t  cyc dat
    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 32'hDEADBEEF, 32'h0,        4'hF, 1,  0, 0, 0, 0, 2, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 32'h0,        32'h0,        4'hF, 1,  0, 0, 1, 0, 2, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 32'h12345678, 32'h0,        4'h3, 0,  0, 0, 0, 0, 1, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 32'h0,        32'h0,        4'hF, 2,  9, 0, 0, 0, 3, 32'h12345678};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 32'h0,        32'h0,        4'hF, 1,  0, 1, 1, 1, 2, 32'h12345678};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h20, 32'h0,        32'hCAFEF00D, 4'hC, 3,  1, 2, 1, 2, 4, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0,        32'h0,        4'hF, 4,  2, 0, 0, 0, 5, 32'hDEADBEEF};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 32'h0,        32'h0,        4'hF, -1, 0, 0, 0, 1, 5, 32'hDEADBEEF};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 32'h0,        32'h0,        4'hF, 1,  0, 0, 1, 0, 2, 32'hDEADBEEF};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 32'h0,        32'h0,        4'hF, 0,  0, 0, 0, 0, 1, 32'h12345678};

    // Reset state, with both masters requesting during reset.
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    @(negedge clk); @(negedge clk);
    chk("rst stall", {30'd0, m0_stall, m1_stall}, 32'd3);
    chk("rst wb cyc/stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    chk("rst terms", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 32'd0);
    chk("rst dats", m0_dout | m1_dout, 32'd0);
    chk("rst fwd", 32'({wb_adr, wb_sel, wb_we}) | wb_dout, 32'd0);
    idle_all();
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Contention straight after reset: m0, m1, m0, m1 with both always requesting.
    reset_dut();
    m0_we = 0; m1_we = 0; m0_adr = 8'h40; m1_adr = 8'h44;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d stall", k), {30'd0, m1_stall, m0_stall}, (k % 2 == 0) ? 32'd2 : 32'd1);
      @(negedge clk);
      chk($sformatf("rr%0d adr", k), 32'(wb_adr), (k % 2 == 0) ? 32'h40 : 32'h44);
      chk($sformatf("rr%0d loser stall", k), 32'((k % 2 == 0) ? m1_stall : m0_stall), 32'd1);
      wb_ack = 1; wb_din = 32'hA0 + k;
      @(negedge clk);
      wb_ack = 0;
      chk($sformatf("rr%0d ack", k), {30'd0, m1_ack, m0_ack}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d dat", k), (k % 2 == 0) ? m0_dout : m1_dout, 32'hA0 + k);
    end
    idle_all();
    @(negedge clk);

    // Timeout on m0, then m1 (waiting meanwhile) is served right after.
    m0_adr = 8'h50; m1_adr = 8'h54; m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    chk("to req", 32'(wb_cyc), 32'd1);
    m0_stb = 0; m1_cyc = 1; m1_stb = 1;
    #1;
    chk("to m1 stall", 32'(m1_stall), 32'd1);
    repeat (TO) @(negedge clk);
    chk("to not early", 32'(m0_err), 32'd0);
    @(negedge clk);
    chk("to err", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 32'b010000);
    chk("to cyc low", 32'(wb_cyc), 32'd0);
    chk("to m1 accept", 32'(m1_stall), 32'd0);
    m0_cyc = 0;
    @(negedge clk);
    chk("to m1 fwd", {23'd0, wb_cyc, wb_adr}, 32'h154);
    m1_stb = 0; wb_ack = 1; wb_din = 32'h77;
    @(negedge clk);
    wb_ack = 0;
    chk("to m1 ack", {30'd0, m1_ack, m0_ack}, 32'd2);
    chk("to m1 dat", m1_dout, 32'h77);
    idle_all();
    @(negedge clk);

    // Abort: m1 drops cyc in WAIT; a late ack must not reach anyone.
    m1_adr = 8'h60; m1_cyc = 1; m1_stb = 1;
    @(negedge clk);
    m1_stb = 0;
    @(negedge clk);
    chk("abort in wait", {30'd0, wb_cyc, wb_stb}, 32'd2);
    m1_cyc = 0;
    @(negedge clk);
    chk("abort cyc low", 32'(wb_cyc), 32'd0);
    chk("abort no term", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 32'd0);
    @(negedge clk);
    wb_ack = 1; wb_din = 32'h99;
    @(negedge clk);
    wb_ack = 0;
    chk("abort late ack", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 32'd0);
    chk("abort dat held", m1_dout, 32'h77);
    @(negedge clk);

    // Reset in WAIT, then contention grants m0.
    m0_adr = 8'h70; m1_adr = 8'h74; m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    m0_stb = 0;
    @(negedge clk);
    chk("rstw in wait", {30'd0, wb_cyc, wb_stb}, 32'd2);
    rst = 1;
    @(negedge clk);
    chk("rstw cyc low", 32'(wb_cyc), 32'd0);
    chk("rstw no term", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 32'd0);
    rst = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    #1;
    chk("rstw grant m0", {30'd0, m1_stall, m0_stall}, 32'd2);
    @(negedge clk);
    chk("rstw fwd", {23'd0, wb_cyc, wb_adr}, 32'h170);
    idle_all();
    m0_cyc = 1; wb_ack = 1; wb_din = 32'h5A5A5A5A;
    @(negedge clk);
    chk("rstw ack", {30'd0, m1_ack, m0_ack}, 32'd1);
    idle_all();
    @(negedge clk);

    // Randomized transactions against the transaction-level model.
    reset_dut();
    mdl_last = 1;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(1, 3));
      v.r0 = (r & 1) != 0;
      v.r1 = (r & 2) != 0;
      v.we = $urandom_range(0, 1) != 0;
      v.adr0 = 8'($urandom_range(0, 15) * 4);
      v.adr1 = 8'($urandom_range(16, 31) * 4);
      v.dat0 = $urandom;
      v.dat1 = $urandom;
      v.sel = 4'($urandom_range(0, 15));
      v.lat = int'($urandom_range(0, 6));
      v.stl = int'($urandom_range(0, 6));
      v.kind = int'($urandom_range(0, 2));
      v.exp_g = (v.r0 && v.r1) ? (mdl_last == 1 ? 0 : 1) : (v.r1 ? 1 : 0);
      mdl_last = v.exp_g;
      if (v.lat <= TO) begin
        v.exp_term = v.kind;
        v.exp_cyc = v.lat + 1;
        v.exp_dat = v.we ? 32'h0 : ref_mem[v.exp_g ? v.adr1 : v.adr0];
      end else begin
        v.exp_term = 1;
        v.exp_cyc = TO + 1;
        v.exp_dat = hold[v.exp_g];
      end
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
